// File: rtl/riscv_pkg.sv
// Shared RV32 execute-stage definitions used by the multiplier slice.
package riscv_pkg;

   localparam int unsigned XLEN      = 32;
   localparam int unsigned MUL_CNT_W = 5;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } mul_state_t;

endpackage

// File: rtl/mul_seq_ctrl_if.sv
// Start/busy/done handshake and operand/result bus of the sequential multiplier.
interface mul_seq_ctrl_if;
   import riscv_pkg::*;

   logic              start;
   logic              flush;
   logic [XLEN-1:0]   op_a;
   logic [XLEN-1:0]   op_b;
   logic              busy;
   logic              done;
   logic [2*XLEN-1:0] result;

   modport master (
      output start, flush, op_a, op_b,
      input  busy, done, result
   );

   modport slave (
      input  start, flush, op_a, op_b,
      output busy, done, result
   );

endinterface

// File: rtl/mul_seq_ctrl_add.sv
// 32-bit ripple-carry adder built from per-bit full-adder equations.
module mul_seq_ctrl_add
   import riscv_pkg::*;
(
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic            c_in,
   output logic [XLEN-1:0] sum,
   output logic            c_out
);

   // Carry ripples bit by bit from c_in up to c_out.
   always_comb begin
      logic carry;
      carry = c_in;
      sum   = '0;
      for (int unsigned i = 0; i < XLEN; i++) begin
         sum[i] = a[i] ^ b[i] ^ carry;
         carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
      end
      c_out = carry;
   end

endmodule

// File: rtl/mul_seq_ctrl.sv
// Shift-add 32x32->64 unsigned multiplier controller, one multiplier bit per
// cycle, sharing a single ripple adder. The pipeline stalls while busy is high.
module mul_seq_ctrl
   import riscv_pkg::*;
#(
   parameter bit EARLY_EXIT = 1'b0
)
(
   input  logic           clk,
   input  logic           rst,
   mul_seq_ctrl_if.slave  bus
);

   localparam int unsigned N_ITER = XLEN;

   mul_state_t           state;
   logic [XLEN-1:0]      mcand;
   logic [XLEN-1:0]      acc_hi;
   logic [XLEN-1:0]      acc_lo;
   logic [MUL_CNT_W-1:0] cnt;

   logic [XLEN-1:0]      addend;
   logic [XLEN-1:0]      add_sum;
   logic                 add_cout;
   logic [2*XLEN-1:0]    acc_next;
   logic [2*XLEN-1:0]    acc_final;
   logic [XLEN-1:0]      rem_mask;
   logic                 rem_zero;
   logic                 last_iter;
   logic [MUL_CNT_W-1:0] shamt;

   mul_seq_ctrl_add u_add (
      .a     (acc_hi),
      .b     (addend),
      .c_in  (1'b0),
      .sum   (add_sum),
      .c_out (add_cout)
   );

   // One shift-add step; also decides whether this is the final iteration.
   always_comb begin
      addend   = acc_lo[0] ? mcand : '0;
      acc_next = {add_cout, add_sum, acc_lo[XLEN-1:1]};
      // acc_lo[31-cnt:0] still holds unconsumed multiplier bits; bit 0 is
      // consumed now, so the ones left after the shift are acc_lo[31-cnt:1].
      rem_mask  = {XLEN{1'b1}} >> cnt;
      rem_zero  = ((acc_lo & rem_mask) >> 1) == '0;
      last_iter = (cnt == MUL_CNT_W'(N_ITER - 1)) || (EARLY_EXIT && rem_zero);
      // Skipped iterations would only shift right with a zero addend, so an
      // early exit applies all of them at once: 31-cnt positions.
      shamt     = ~cnt;
      acc_final = EARLY_EXIT ? (acc_next >> shamt) : acc_next;
   end

   // Controller FSM with registered busy/done/result.
   // The product is committed on the edge entering DONE so that result and
   // done become visible in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         mcand      <= '0;
         acc_hi     <= '0;
         acc_lo     <= '0;
         cnt        <= '0;
         bus.busy   <= 1'b0;
         bus.done   <= 1'b0;
         bus.result <= '0;
      end else begin
         case (state)
            IDLE: begin
               bus.done <= 1'b0;
               if (bus.start && !bus.flush) begin
                  state    <= BUSY;
                  bus.busy <= 1'b1;
                  mcand    <= bus.op_a;
                  acc_hi   <= '0;
                  acc_lo   <= bus.op_b;
                  cnt      <= '0;
               end
            end
            BUSY: begin
               if (bus.flush) begin
                  state    <= IDLE;
                  bus.busy <= 1'b0;
                  cnt      <= '0;
               end else if (last_iter) begin
                  state            <= DONE;
                  bus.busy         <= 1'b0;
                  bus.done         <= 1'b1;
                  {acc_hi, acc_lo} <= acc_final;
                  bus.result       <= acc_final;
                  cnt              <= '0;
               end else begin
                  {acc_hi, acc_lo} <= acc_next;
                  cnt              <= cnt + 1'b1;
               end
            end
            DONE: begin
               state    <= IDLE;
               bus.done <= 1'b0;
            end
            default: begin
               state    <= IDLE;
               bus.busy <= 1'b0;
               bus.done <= 1'b0;
            end
         endcase
      end
   end

endmodule
